regfile_wb_ctrl: RTL
====================

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have issue ports: iss_valid in 1; iss_rs1 in 5; iss_rs2 in 5; iss_rd in 5; iss_uses_rd in 1 (instruction writes rd); iss_long in 1 (rd produced by long-latency unit).
REQ-003 SHALL have output iss_stall  out  1  (issue blocked this cycle).
REQ-004 SHALL have writeback requester 0 (ALU pipe): wb0_valid in 1; wb0_rd in 5; wb0_data in 32; wb0_ready out 1.
REQ-005 SHALL have writeback requester 1 (long-latency unit): wb1_valid in 1; wb1_rd in 5; wb1_data in 32; wb1_ready out 1.
REQ-006 SHALL have regfile write port: rf_load out 1; rf_dest out 5; rf_in out 32.
REQ-007 SHALL have status: busy_vec out 32 (bit0 always 0); outstanding out 6 (count of busy registers); err out 1 (sticky protocol error).

Function
REQ-008 Arbitration SHALL be combinational, one grant per cycle; wbN_ready=1 means wbN transfers this cycle.
REQ-009 Only one valid: that requester SHALL be granted.
REQ-010 Both valid: grant SHALL go to the requester not granted most recently (round-robin); last_grant register updates only on a grant.
REQ-011 rf_load SHALL equal (grant && granted rd != 0); rf_dest/rf_in SHALL carry granted rd/data; rf_dest=0, rf_in=0 when no grant.
REQ-012 A granted write to rd=0 SHALL still assert the requester's ready but SHALL not assert rf_load.
REQ-013 Scoreboard busy[r] SHALL set on the clock edge where issue is accepted (iss_valid && !iss_stall) with iss_uses_rd && iss_long && iss_rd!=0.
REQ-014 busy[r] SHALL clear on the clock edge where wb1 is granted with wb1_rd=r.
REQ-015 Same-edge set and clear of the same r SHALL leave busy[r]=1 (set wins).
REQ-016 iss_stall SHALL be 1 when iss_valid and any of rs1, rs2, or (rd when iss_uses_rd) is nonzero and busy, excluding a register being cleared by a wb1 grant this cycle (regfile write-through covers the read).
REQ-017 iss_stall SHALL be 1 when iss_valid && iss_uses_rd && !iss_long && wb1_valid and rd is busy (WAW); iss_stall SHALL be 0 when iss_valid=0.
REQ-018 outstanding SHALL equal popcount(busy_vec) registered, range 0..31, never wrapping.
REQ-019 err SHALL set and hold when wb1 is granted with nonzero wb1_rd whose busy bit is 0, or wb0 is granted with nonzero wb0_rd whose busy bit is 1.
REQ-020 Requesters SHALL hold valid/rd/data stable until ready; the block SHALL not buffer data (zero-latency path).

Reset
REQ-021 On rst: busy_vec=0, outstanding=0, err=0, last_grant=wb1 (so wb0 wins first contention).
REQ-022 During rst: rf_load=0, wb0_ready=0, wb1_ready=0, iss_stall=1.
REQ-023 rst mid-operation SHALL discard all outstanding busy state in one cycle; no writeback completes in the reset cycle.

Structure
REQ-024 Shared package SHALL hold reg-index width (5), data width (32), register count (32), and grant-select enum {GNT_NONE, GNT_WB0, GNT_WB1}.
REQ-025 Round-robin two-way arbiter SHALL be a sub-module rr_arb2 (req[1:0], gnt[1:0], state); scoreboard stays in the top module.

Verification
REQ-026 Issue long-latency rd=5 -> busy_vec[5]=1, outstanding=1; issue rs1=5 next cycle -> iss_stall=1; wb1 rd=5 granted -> same-cycle iss_stall=0, next cycle busy_vec[5]=0.
REQ-027 wb0 and wb1 valid together for 4 cycles after reset -> grant order wb0, wb1, wb0, wb1; rf_dest/rf_in match granted source each cycle.
REQ-028 wb0 rd=0 data=0xDEADBEEF -> wb0_ready=1, rf_load=0.
REQ-029 wb1 rd=7 with busy_vec[7]=0 -> err=1 and stays 1 until rst.
REQ-030 Issue long rd=3 while wb1 clears rd=3 same cycle -> busy_vec[3]=1 after edge, outstanding unchanged.
REQ-031 Set busy on regs 1..4, assert rst one cycle -> busy_vec=0, outstanding=0, err=0, next contention grants wb0.

Source files
------------

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared widths, grant-select encoding and small helpers for the regfile
// writeback controller.
package regfile_wb_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB0  = 2'd1,
    GNT_WB1  = 2'd2
  } gnt_sel_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

  function automatic logic [CNT_W-1:0] reg_popcount(input logic [NUM_REGS-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; state names the requester granted most
// recently (0 = wb0, 1 = wb1).
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       state,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = state ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback arbitration onto a single regfile write port plus a busy-register
// scoreboard that stalls issue on hazards against the long-latency unit.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid,
  input  logic [REG_IDX_W-1:0] iss_rs1,
  input  logic [REG_IDX_W-1:0] iss_rs2,
  input  logic [REG_IDX_W-1:0] iss_rd,
  input  logic                 iss_uses_rd,
  input  logic                 iss_long,
  output logic                 iss_stall,
  input  logic                 wb0_valid,
  input  logic [REG_IDX_W-1:0] wb0_rd,
  input  logic [DATA_W-1:0]    wb0_data,
  output logic                 wb0_ready,
  input  logic                 wb1_valid,
  input  logic [REG_IDX_W-1:0] wb1_rd,
  input  logic [DATA_W-1:0]    wb1_data,
  output logic                 wb1_ready,
  output logic                 rf_load,
  output logic [REG_IDX_W-1:0] rf_dest,
  output logic [DATA_W-1:0]    rf_in,
  output logic [NUM_REGS-1:0]  busy_vec,
  output logic [CNT_W-1:0]     outstanding,
  output logic                 err
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic                err_q, err_d;
  logic                last_grant_q, last_grant_d;

  logic [1:0]          arb_gnt;
  gnt_sel_e            sel;
  logic [NUM_REGS-1:0] clr_vec, set_vec, busy_eff;
  logic                hazard, waw, accept;

  rr_arb2 u_arb (
    .req   ({wb1_valid, wb0_valid}),
    .state (last_grant_q),
    .gnt   (arb_gnt)
  );

  // Grant decode and zero-latency write port mux; no grants while in reset.
  always_comb begin
    sel          = GNT_NONE;
    rf_dest      = '0;
    rf_in        = '0;
    rf_load      = 1'b0;
    last_grant_d = last_grant_q;
    if (!rst) begin
      if (arb_gnt[0])      sel = GNT_WB0;
      else if (arb_gnt[1]) sel = GNT_WB1;
    end
    unique case (sel)
      GNT_WB0: begin
        rf_dest      = wb0_rd;
        rf_in        = wb0_data;
        rf_load      = (wb0_rd != '0);
        last_grant_d = 1'b0;
      end
      GNT_WB1: begin
        rf_dest      = wb1_rd;
        rf_in        = wb1_data;
        rf_load      = (wb1_rd != '0);
        last_grant_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign wb0_ready = (sel == GNT_WB0);
  assign wb1_ready = (sel == GNT_WB1);

  // Hazard detection; a register retired by wb1 this cycle reads via write-through.
  always_comb begin
    clr_vec  = (wb1_ready && wb1_rd != '0) ? reg_onehot(wb1_rd) : '0;
    busy_eff = busy_q & ~clr_vec;
    hazard   = ((iss_rs1 != '0) && busy_eff[iss_rs1]) ||
               ((iss_rs2 != '0) && busy_eff[iss_rs2]) ||
               (iss_uses_rd && (iss_rd != '0) && busy_eff[iss_rd]);
    waw      = iss_uses_rd && !iss_long && wb1_valid &&
               (iss_rd != '0) && busy_q[iss_rd];
    iss_stall = rst || (iss_valid && (hazard || waw));
    accept    = iss_valid && !iss_stall;
  end

  // Scoreboard next state; set wins over a same-edge clear.
  always_comb begin
    set_vec = (accept && iss_uses_rd && iss_long && iss_rd != '0) ?
              reg_onehot(iss_rd) : '0;
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
    outstanding_d = reg_popcount(busy_d);
    err_d = err_q ||
            (wb1_ready && (wb1_rd != '0) && !busy_q[wb1_rd]) ||
            (wb0_ready && (wb0_rd != '0) &&  busy_q[wb0_rd]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      last_grant_q  <= 1'b1;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign busy_vec    = busy_q;
  assign outstanding = outstanding_q;
  assign err         = err_q;

endmodule
